// File: rtl/recip_x_pkg.sv
// rtl/recip_x_pkg.sv - shared flag/rounding encodings and helpers for the reciprocal unit
// Contents: class, exception and rounding-attribute one-hot indices (MSB-first in listing
// order), the control FSM state type, and rounding-decision helpers.
package recip_x_pkg;

   // one-hot result class (rFlags)
   localparam int NTYPES    = 6;
   localparam int SNAN      = 5;
   localparam int QNAN      = 4;
   localparam int INFINITY  = 3;
   localparam int ZERO      = 2;
   localparam int SUBNORMAL = 1;
   localparam int NORMAL    = 0;

   // exception vector {invalid, divideByZero, overflow, underflow, inexact}
   localparam int NEXCEPTIONS  = 5;
   localparam int INVALID      = 4;
   localparam int DIVIDEBYZERO = 3;
   localparam int OVERFLOW     = 2;
   localparam int UNDERFLOW    = 1;
   localparam int INEXACT      = 0;

   // one-hot rounding attribute
   localparam int NRAS                  = 5;
   localparam int ROUND_TIES_TO_EVEN    = 4;
   localparam int ROUND_TIES_TO_AWAY    = 3;
   localparam int ROUND_TOWARD_ZERO     = 2;
   localparam int ROUND_TOWARD_POSITIVE = 1;
   localparam int ROUND_TOWARD_NEGATIVE = 0;

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_RND, ST_DONE} state_t;

   // g is the half-ulp bit, s the OR of everything below it
   function automatic logic round_up(input logic [NRAS-1:0] ra, input logic sign,
                                     input logic lsb, input logic g, input logic s);
      logic up;
      up = 1'b0;
      if (ra[ROUND_TIES_TO_EVEN])
         up = g & (s | lsb);
      else if (ra[ROUND_TIES_TO_AWAY])
         up = g;
      else if (ra[ROUND_TOWARD_ZERO])
         up = 1'b0;
      else if (ra[ROUND_TOWARD_POSITIVE])
         up = ~sign & (g | s);
      else if (ra[ROUND_TOWARD_NEGATIVE])
         up = sign & (g | s);
      return up;
   endfunction

   // overflow saturates to infinity unless rounding is toward zero for this sign
   function automatic logic ovf_to_inf(input logic [NRAS-1:0] ra, input logic sign);
      return ra[ROUND_TIES_TO_EVEN] | ra[ROUND_TIES_TO_AWAY] |
             (ra[ROUND_TOWARD_POSITIVE] & ~sign) | (ra[ROUND_TOWARD_NEGATIVE] & sign);
   endfunction

endpackage

// File: rtl/fp_class.sv
// rtl/fp_class.sv - operand classifier and normaliser for binaryN values
// Ports: a    operand {sign, exp, frac}
//        sign operand sign
//        cls  one-hot class of a
//        e    unbiased exponent of the normalised value 1.f*2^e (finite nonzero only)
//        sig  significand with hidden bit, MSB always set for finite nonzero operands
module fp_class import recip_x_pkg::*; #(
   parameter int NEXP = 5,
   parameter int NSIG = 10
) (
   input  logic [NEXP+NSIG:0]      a,
   output logic                    sign,
   output logic [NTYPES-1:0]       cls,
   output logic signed [NEXP+1:0]  e,
   output logic [NSIG:0]           sig
);

   localparam int BIAS = 2**(NEXP-1) - 1;
   localparam int EMIN = 1 - BIAS;
   localparam int EW   = NEXP + 2;

   logic [NEXP-1:0] exp_f;
   logic [NSIG-1:0] frac;
   int              lz;

   assign sign  = a[NEXP+NSIG];
   assign exp_f = a[NEXP+NSIG-1:NSIG];
   assign frac  = a[NSIG-1:0];

   // leading zeros of the fraction: the highest set bit wins
   always_comb begin
      lz = 0;
      for (int i = 0; i < NSIG; i++)
         if (frac[i]) lz = NSIG - 1 - i;
   end

   always_comb begin
      cls = '0;
      e   = '0;
      sig = '0;
      if (&exp_f) begin
         if (frac == '0)        cls[INFINITY] = 1'b1;
         else if (frac[NSIG-1]) cls[QNAN]     = 1'b1;
         else                   cls[SNAN]     = 1'b1;
      end else if (exp_f == '0) begin
         if (frac == '0) begin
            cls[ZERO] = 1'b1;
         end else begin
            // 0.f*2^EMIN: move the leading one up to the hidden-bit position
            cls[SUBNORMAL] = 1'b1;
            e   = EW'(EMIN - 1 - lz);
            sig = {1'b0, frac} << (lz + 1);
         end
      end else begin
         cls[NORMAL] = 1'b1;
         e   = EW'(int'(exp_f) - BIAS);
         sig = {1'b1, frac};
      end
   end

endmodule

// File: rtl/recip_x.sv
// rtl/recip_x.sv - multicycle correctly rounded IEEE 754 reciprocal 1/a
// Ports: clk, rst_n (async active-low), start (samples a/ra),
//        a operand, ra one-hot rounding attribute,
//        r result, rFlags one-hot class of r, exception flags, done one-cycle pulse.
// Latency from the sampling edge to done is NSIG+4 edges for every operand class.
module recip_x import recip_x_pkg::*; #(
   parameter int NEXP = 5,
   parameter int NSIG = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NEXP+NSIG:0]     a,
   input  logic [NRAS-1:0]        ra,
   output logic [NEXP+NSIG:0]     r,
   output logic [NTYPES-1:0]      rFlags,
   output logic [NEXCEPTIONS-1:0] exception,
   output logic                   done
);

   localparam int N    = NEXP + NSIG + 1;
   localparam int BIAS = 2**(NEXP-1) - 1;
   localparam int EW   = NEXP + 2;
   localparam int SW   = NSIG + 3;            // integer bit, NSIG fraction bits, guard, round
   localparam int CW   = $clog2(NSIG + 2) + 1;
   localparam logic signed [EW-1:0] EMAX_S = EW'(BIAS);
   localparam logic signed [EW-1:0] EMIN_S = EW'(1 - BIAS);
   localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
   localparam logic signed [EW-1:0] ONE_E  = EW'(1);
   localparam logic [NSIG:0]        ONE_R  = (NSIG+1)'(1);
   localparam logic [CW-1:0]        DIV_LAST = CW'(NSIG + 1);

   logic                   a_sign;
   logic [NTYPES-1:0]      a_cls;
   logic signed [EW-1:0]   a_e;
   logic [NSIG:0]          a_sig;

   fp_class #(.NEXP(NEXP), .NSIG(NSIG)) u_class (
      .a    (a),
      .sign (a_sign),
      .cls  (a_cls),
      .e    (a_e),
      .sig  (a_sig)
   );

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [N-1:0]            opnd_q, opnd_d;
   logic [NRAS-1:0]         ra_q, ra_d;
   logic                    sign_q, sign_d;
   logic [NTYPES-1:0]       cls_q, cls_d;
   logic signed [EW-1:0]    exp_q, exp_d;
   logic [NSIG:0]           dvsr_q, dvsr_d;
   logic [NSIG:0]           rem_q, rem_d;
   logic [SW-1:0]           quo_q, quo_d;
   logic                    pow2_q, pow2_d;
   logic [N-1:0]            res_q, res_d;
   logic [NTYPES-1:0]       res_cls_q, res_cls_d;
   logic [NEXCEPTIONS-1:0]  res_exc_q, res_exc_d;
   logic [N-1:0]            r_q, r_d;
   logic [NTYPES-1:0]       flags_q, flags_d;
   logic [NEXCEPTIONS-1:0]  exc_q, exc_d;
   logic                    done_q, done_d;

   assign r         = r_q;
   assign rFlags    = flags_q;
   assign exception = exc_q;
   assign done      = done_q;

   // restoring division step: remainder doubles, divisor subtracted when it fits
   logic [NSIG+1:0] rem2, dif;
   logic            step_bit;
   logic [NSIG:0]   step_rem;

   always_comb begin
      rem2     = {rem_q, 1'b0};
      dif      = rem2 - {1'b0, dvsr_q};
      step_bit = (rem2 >= {1'b0, dvsr_q});
      step_rem = (NSIG+1)'(step_bit ? dif : rem2);
   end

   // rounding and special-case selection, evaluated while in RND
   logic signed [EW-1:0]   re, sh, e_eff, e_fin, be;
   logic [EW-1:0]          sh_u;
   logic [SW-1:0]          ext, ext_sh, mask;
   logic [NSIG:0]          sig_t;
   logic [NSIG+1:0]        sum;
   logic [NSIG-1:0]        frac_t;
   logic                   g, stk, inc, hidden, ovf, inexact;
   logic [N-1:0]           rnd_r;
   logic [NEXCEPTIONS-1:0] rnd_x;
   logic [NTYPES-1:0]      rnd_c;
   logic [NEXP-1:0]        rx_exp;
   logic [NSIG-1:0]        rx_frac;

   always_comb begin
      // f==0 gives exactly 2^-e; otherwise the quotient holds 2q in (1,2) so 1/a = 2q*2^(-e-1)
      re  = pow2_q ? -exp_q : -exp_q - ONE_E;
      ext = pow2_q ? {1'b1, {(SW-1){1'b0}}} : quo_q;
      stk = ~pow2_q & (|rem_q);
      if (re < EMIN_S) begin
         sh    = EMIN_S - re;
         e_eff = EMIN_S;
      end else begin
         sh    = '0;
         e_eff = re;
      end
      sh_u   = sh;
      mask   = ~({SW{1'b1}} << sh_u);
      stk    = stk | (|(ext & mask));
      ext_sh = ext >> sh_u;
      sig_t  = ext_sh[SW-1:2];
      g      = ext_sh[1];
      stk    = stk | ext_sh[0];
      inc    = round_up(ra_q, sign_q, sig_t[0], g, stk);
      sum    = {1'b0, sig_t} + {{(NSIG+1){1'b0}}, inc};
      // a carry out of the significand renormalises to 1.0 with the next exponent;
      // a subnormal rounding into the hidden bit becomes the smallest normal naturally
      if (sum[NSIG+1]) begin
         hidden = 1'b1;
         frac_t = '0;
         e_fin  = e_eff + ONE_E;
      end else begin
         hidden = sum[NSIG];
         frac_t = sum[NSIG-1:0];
         e_fin  = e_eff;
      end
      be      = e_fin + BIAS_S;
      inexact = g | stk;
      ovf     = hidden && (e_fin > EMAX_S);

      rnd_r = '0;
      rnd_x = '0;
      if (cls_q[SNAN]) begin
         rnd_r          = opnd_q | (N'(1) << (NSIG - 1));
         rnd_x[INVALID] = 1'b1;
      end else if (cls_q[QNAN]) begin
         rnd_r = opnd_q;
      end else if (cls_q[INFINITY]) begin
         rnd_r = {sign_q, {(N-1){1'b0}}};
      end else if (cls_q[ZERO]) begin
         rnd_r               = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
         rnd_x[DIVIDEBYZERO] = 1'b1;
      end else if (cls_q[SUBNORMAL] | cls_q[NORMAL]) begin
         if (ovf) begin
            rnd_x[OVERFLOW] = 1'b1;
            rnd_x[INEXACT]  = 1'b1;
            if (ovf_to_inf(ra_q, sign_q))
               rnd_r = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
            else
               rnd_r = {sign_q, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
         end else begin
            rnd_r            = {sign_q, (hidden ? NEXP'(be) : {NEXP{1'b0}}), frac_t};
            rnd_x[INEXACT]   = inexact;
            rnd_x[UNDERFLOW] = ~hidden & inexact;
         end
      end
   end

   always_comb begin
      rx_exp  = rnd_r[N-2:NSIG];
      rx_frac = rnd_r[NSIG-1:0];
      rnd_c   = '0;
      if (&rx_exp) begin
         if (rx_frac == '0)        rnd_c[INFINITY] = 1'b1;
         else if (rx_frac[NSIG-1]) rnd_c[QNAN]     = 1'b1;
         else                      rnd_c[SNAN]     = 1'b1;
      end else if (rx_exp == '0) begin
         if (rx_frac == '0) rnd_c[ZERO]      = 1'b1;
         else               rnd_c[SUBNORMAL] = 1'b1;
      end else begin
         rnd_c[NORMAL] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opnd_d    = opnd_q;
      ra_d      = ra_q;
      sign_d    = sign_q;
      cls_d     = cls_q;
      exp_d     = exp_q;
      dvsr_d    = dvsr_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      pow2_d    = pow2_q;
      res_d     = res_q;
      res_cls_d = res_cls_q;
      res_exc_d = res_exc_q;
      r_d       = r_q;
      flags_d   = flags_q;
      exc_d     = exc_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_DIV;
               cnt_d   = '0;
               opnd_d  = a;
               ra_d    = ra;
               sign_d  = a_sign;
               cls_d   = a_cls;
               exp_d   = a_e;
               dvsr_d  = a_sig;
               pow2_d  = (a_sig[NSIG-1:0] == '0);
               // the integer quotient bit of 2/1.f is always 1, so start from 2 - 1.f
               rem_d   = ~a_sig + ONE_R;
               quo_d   = SW'(1);
            end
         end
         ST_DIV: begin
            quo_d = {quo_q[SW-2:0], step_bit};
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DIV_LAST) state_d = ST_RND;
         end
         ST_RND: begin
            res_d     = rnd_r;
            res_cls_d = rnd_c;
            res_exc_d = rnd_x;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            r_d     = res_q;
            flags_d = res_cls_q;
            exc_d   = res_exc_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         opnd_q    <= '0;
         ra_q      <= '0;
         sign_q    <= 1'b0;
         cls_q     <= '0;
         exp_q     <= '0;
         dvsr_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         pow2_q    <= 1'b0;
         res_q     <= '0;
         res_cls_q <= '0;
         res_exc_q <= '0;
         r_q       <= '0;
         flags_q   <= '0;
         exc_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opnd_q    <= opnd_d;
         ra_q      <= ra_d;
         sign_q    <= sign_d;
         cls_q     <= cls_d;
         exp_q     <= exp_d;
         dvsr_q    <= dvsr_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         pow2_q    <= pow2_d;
         res_q     <= res_d;
         res_cls_q <= res_cls_d;
         res_exc_q <= res_exc_d;
         r_q       <= r_d;
         flags_q   <= flags_d;
         exc_q     <= exc_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_recip_x.sv
// tb/tb_recip_x.sv - directed bench for recip_x in binary16/32/64/128
module tb_recip_x;

   localparam logic [4:0] RNE = 5'b10000;
   localparam logic [4:0] RTZ = 5'b00100;
   localparam logic [4:0] X_NONE = 5'b00000;
   localparam logic [4:0] X_INV  = 5'b10000;
   localparam logic [4:0] X_DZ   = 5'b01000;
   localparam logic [4:0] X_OFNX = 5'b00101;
   localparam logic [4:0] X_UFNX = 5'b00011;
   localparam logic [4:0] X_NX   = 5'b00001;
   localparam logic [5:0] C_QNAN = 6'b010000;
   localparam logic [5:0] C_INF  = 6'b001000;
   localparam logic [5:0] C_ZERO = 6'b000100;
   localparam logic [5:0] C_SUB  = 6'b000010;
   localparam logic [5:0] C_NORM = 6'b000001;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic s16, s32, s64, s128;
   logic [15:0]  a16, r16;
   logic [31:0]  a32, r32;
   logic [63:0]  a64, r64;
   logic [127:0] a128, r128;
   logic [4:0]   ra16, ra32, ra64, ra128;
   logic [5:0]   f16, f32, f64, f128;
   logic [4:0]   x16, x32, x64, x128;
   logic         d16, d32, d64, d128;

   recip_x #(.NEXP(5), .NSIG(10)) u16 (.clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .ra(ra16),
      .r(r16), .rFlags(f16), .exception(x16), .done(d16));
   recip_x #(.NEXP(8), .NSIG(23)) u32 (.clk(clk), .rst_n(rst_n), .start(s32), .a(a32), .ra(ra32),
      .r(r32), .rFlags(f32), .exception(x32), .done(d32));
   recip_x #(.NEXP(11), .NSIG(52)) u64 (.clk(clk), .rst_n(rst_n), .start(s64), .a(a64), .ra(ra64),
      .r(r64), .rFlags(f64), .exception(x64), .done(d64));
   recip_x #(.NEXP(15), .NSIG(112)) u128 (.clk(clk), .rst_n(rst_n), .start(s128), .a(a128), .ra(ra128),
      .r(r128), .rFlags(f128), .exception(x128), .done(d128));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int fmt, output logic d, output logic [127:0] rr,
                         output logic [4:0] xx, output logic [5:0] ff);
      case (fmt)
         16:      begin d = d16;  rr = 128'(r16); xx = x16;  ff = f16;  end
         32:      begin d = d32;  rr = 128'(r32); xx = x32;  ff = f32;  end
         64:      begin d = d64;  rr = 128'(r64); xx = x64;  ff = f64;  end
         default: begin d = d128; rr = r128;      xx = x128; ff = f128; end
      endcase
   endtask

   // poke > 0: re-pulse start on the binary16 unit that many edges into the operation
   task automatic run(input int fmt, input logic [127:0] av, input logic [4:0] rav,
                      input logic [127:0] er, input logic [4:0] ex, input logic [5:0] ef,
                      input string tag, input int poke);
      int n, lat;
      logic d;
      logic [127:0] rr;
      logic [4:0] xx;
      logic [5:0] ff;
      case (fmt)
         16:      lat = 14;
         32:      lat = 27;
         64:      lat = 56;
         default: lat = 116;
      endcase
      @(negedge clk);
      case (fmt)
         16:      begin a16 = av[15:0];  ra16 = rav;  s16 = 1'b1;  end
         32:      begin a32 = av[31:0];  ra32 = rav;  s32 = 1'b1;  end
         64:      begin a64 = av[63:0];  ra64 = rav;  s64 = 1'b1;  end
         default: begin a128 = av;       ra128 = rav; s128 = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      s16 = 1'b0; s32 = 1'b0; s64 = 1'b0; s128 = 1'b0;
      n = 0;
      sample(fmt, d, rr, xx, ff);
      while (!d && n < 200) begin
         if (poke > 0 && n == poke) begin
            a16 = 16'h0000;
            s16 = 1'b1;
         end else begin
            s16 = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
         sample(fmt, d, rr, xx, ff);
      end
      s16 = 1'b0;
      chk({tag, " latency"}, 128'(n), 128'(lat));
      chk({tag, " r"}, rr, er);
      chk({tag, " exception"}, 128'(xx), 128'(ex));
      chk({tag, " rFlags"}, 128'(ff), 128'(ef));
      @(posedge clk);
      #1;
      sample(fmt, d, rr, xx, ff);
      chk({tag, " done pulse width"}, 128'(d), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ndone;
      logic [127:0] v;
      rst_n = 1'b0;
      s16 = 1'b0; s32 = 1'b0; s64 = 1'b0; s128 = 1'b0;
      a16 = '0; a32 = '0; a64 = '0; a128 = '0;
      ra16 = RNE; ra32 = RNE; ra64 = RNE; ra128 = RNE;
      repeat (3) @(posedge clk);
      #1;
      chk("reset r", 128'(r16), 128'(0));
      chk("reset rFlags", 128'(f16), 128'(0));
      chk("reset exception", 128'(x16), 128'(0));
      chk("reset done", 128'(d16), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run(16, 128'h7d00, RNE, 128'h7f00, X_INV,  C_QNAN, "snan", 0);
      run(16, 128'h7e00, RNE, 128'h7e00, X_NONE, C_QNAN, "qnan", 0);
      run(16, 128'h7c00, RNE, 128'h0000, X_NONE, C_ZERO, "+inf", 0);
      run(16, 128'hfc00, RNE, 128'h8000, X_NONE, C_ZERO, "-inf", 0);
      run(16, 128'h0000, RNE, 128'h7c00, X_DZ,   C_INF,  "+zero", 0);
      run(16, 128'h8000, RNE, 128'hfc00, X_DZ,   C_INF,  "-zero", 0);
      run(16, 128'h3c00, RNE, 128'h3c00, X_NONE, C_NORM, "one", 0);
      run(16, 128'hbc00, RNE, 128'hbc00, X_NONE, C_NORM, "minus one", 0);
      run(16, 128'h4248, RNE, 128'h3518, X_NX,   C_NORM, "h4248", 0);
      run(16, 128'h0514, RNE, 128'h724d, X_NX,   C_NORM, "h0514", 0);
      run(16, 128'h5710, RNE, 128'h2088, X_NX,   C_NORM, "h5710", 0);
      run(16, 128'h7bff, RNE, 128'h0100, X_UFNX, C_SUB,  "max finite", 0);

      for (int i = 0; i < 10; i++) begin
         v = 128'd1 << i;
         if (i <= 8)
            run(16, v, RNE, 128'h7c00, X_OFNX, C_INF, $sformatf("sweep%0d", i), 0);
         else
            run(16, v, RNE, 128'h7800, X_NONE, C_NORM, $sformatf("sweep%0d", i), 0);
      end

      run(16, 128'h0001, RTZ, 128'h7bff, X_OFNX, C_NORM, "min sub rtz", 0);
      run(16, 128'h4248, RNE, 128'h3518, X_NX, C_NORM, "busy start ignored", 5);

      run(32, 128'h40490fdb, RNE, 128'h3ea2f983, X_NX, C_NORM, "b32 pi", 0);
      run(32, 128'h42e20000, RNE, 128'h3c10fdbc, X_NX, C_NORM, "b32 113", 0);
      run(64, 128'h400921fb54442d18, RNE, 128'h3fd45f306dc9c883, X_NX, C_NORM, "b64 pi", 0);
      run(64, 128'h405c400000000000, RNE, 128'h3f821fb78121fb78, X_NX, C_NORM, "b64 113", 0);
      run(128, 128'h4000921fb54442d18469898cc51701b8, RNE,
          128'h3ffd45f306dc9c882a53f84eafa3ea6a, X_NX, C_NORM, "b128 pi", 0);

      // reset part-way through DIV: outputs clear and the aborted operation never completes
      @(negedge clk);
      a16 = 16'h4248;
      s16 = 1'b1;
      @(posedge clk);
      #1;
      s16 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort r", 128'(r16), 128'(0));
      chk("abort rFlags", 128'(f16), 128'(0));
      chk("abort exception", 128'(x16), 128'(0));
      chk("abort done", 128'(d16), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (d16) ndone++;
      end
      chk("abort no done", 128'(ndone), 128'(0));
      run(16, 128'h5710, RNE, 128'h2088, X_NX, C_NORM, "after abort", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
